refresh_scheduler: RTL and testbench

Periodic refresh sequencer for the 8-row GC-DRAM array. Decides when each row is refreshed, arbitrates the array between host read/write traffic and refresh, and drives the read-then-write-back refresh phases. Publishes the row under refresh (ref_mem_addr) and a one-cycle ref_done pulse, which feed SR_CTRL so it can redirect host addresses around the row being refreshed.

---
 rtl/ref_sched_pkg.sv | 22 ++
 rtl/ref_interval_timer.sv | 29 ++
 rtl/refresh_scheduler.sv | 128 ++++++++++++
 tb/tb_refresh_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ref_sched_pkg.sv
// Shared types and defaults for the GC-DRAM refresh scheduler.
package ref_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ref_state_t;

    localparam int DEF_ADDR_W       = 3;
    localparam int DEF_REF_INTERVAL = 64;
    localparam int DEF_RD_CYCLES    = 2;
    localparam int DEF_WR_CYCLES    = 2;
    localparam int DEF_MAX_PEND     = 2;

    // Next row to refresh, wrapping from the last row back to row 0.
    function automatic int unsigned next_row(input int unsigned row, input int unsigned num_rows);
        return (row == num_rows - 1) ? 32'd0 : row + 32'd1;
    endfunction

endpackage

// File: rtl/ref_interval_timer.sv
// Free-running refresh interval timer; emits a one-cycle tick every REF_INTERVAL enabled cycles.
module ref_interval_timer
    import ref_sched_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_en,
    output logic tick
);

    localparam int TW = $clog2(REF_INTERVAL);
    localparam logic [TW-1:0] LAST = TW'(REF_INTERVAL - 1);

    logic [TW-1:0] timer;

    // The count freezes while disabled so the interval resumes where it left off.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (ref_en) begin
            timer <= (timer == LAST) ? '0 : timer + 1'b1;
        end
    end

    assign tick = ref_en && (timer == LAST);

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh sequencer for the 8-row GC-DRAM: pending-refresh bookkeeping, host arbitration, read/write-back phases.
//
//   state | meaning
//   IDLE  | no refresh in flight; may start when refresh is pending and host allows
//   READ  | mem_ref_rd held for RD_CYCLES
//   WRITE | mem_ref_wr held for WR_CYCLES
//   DONE  | ref_done pulse, row pointer advances on exit
module refresh_scheduler
    import ref_sched_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int REF_INTERVAL = DEF_REF_INTERVAL,
    parameter int RD_CYCLES    = DEF_RD_CYCLES,
    parameter int WR_CYCLES    = DEF_WR_CYCLES,
    parameter int MAX_PEND     = DEF_MAX_PEND
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ref_en,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic              host_stall,
    output logic              mem_ref_rd,
    output logic              mem_ref_wr,
    output logic [ADDR_W-1:0] ref_mem_addr,
    output logic              ref_done,
    output logic              ref_busy,
    output logic              ref_urgent,
    output logic              ref_miss
);

    localparam int unsigned NUM_ROWS = 2 ** ADDR_W;
    localparam int PW     = $clog2(MAX_PEND + 1);
    localparam int PH_MAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

    ref_state_t        state;
    logic [PH_W-1:0]   ph_cnt;
    logic [PW-1:0]     pend_cnt;
    logic              tick;
    logic              start_now;
    logic              in_done;

    ref_interval_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .ref_en (ref_en),
        .tick   (tick)
    );

    assign ref_urgent = (pend_cnt == PEND_MAX);
    assign in_done    = (state == DONE);
    assign start_now  = (state == IDLE) && ref_en && (pend_cnt != '0)
                        && (!(wr_req || rd_req) || ref_urgent);
    assign host_stall = (state != IDLE) || start_now;

    // A tick and a completing refresh in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt <= '0;
            ref_miss <= 1'b0;
        end else if (tick && !in_done) begin
            if (pend_cnt == PEND_MAX) begin
                ref_miss <= 1'b1;
            end else begin
                pend_cnt <= pend_cnt + 1'b1;
            end
        end else if (in_done && !tick) begin
            pend_cnt <= pend_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ph_cnt       <= '0;
            ref_mem_addr <= '0;
            mem_ref_rd   <= 1'b0;
            mem_ref_wr   <= 1'b0;
            ref_done     <= 1'b0;
            ref_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_now) begin
                        state      <= READ;
                        ph_cnt     <= PH_W'(RD_CYCLES - 1);
                        mem_ref_rd <= 1'b1;
                        ref_busy   <= 1'b1;
                    end
                end
                READ: begin
                    if (ph_cnt == '0) begin
                        state      <= WRITE;
                        ph_cnt     <= PH_W'(WR_CYCLES - 1);
                        mem_ref_rd <= 1'b0;
                        mem_ref_wr <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt - 1'b1;
                    end
                end
                WRITE: begin
                    if (ph_cnt == '0) begin
                        state      <= DONE;
                        ph_cnt     <= '0;
                        mem_ref_wr <= 1'b0;
                        ref_done   <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    ref_done     <= 1'b0;
                    ref_busy     <= 1'b0;
                    ref_mem_addr <= ADDR_W'(next_row(32'(ref_mem_addr), NUM_ROWS));
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Self-checking bench: two scheduler instances (interval 16 and 4) against a position-based reference model.
module tb_refresh_scheduler;

    localparam int RD = 2, WR = 2, MAXP = 2, LAST = RD + WR + 1;
    localparam int INT_A = 16, INT_B = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, ref_en = 1'b1, wr_req = 1'b0, rd_req = 1'b0;

    logic stall_a, rd_a, wr_a, done_a, busy_a, urg_a, miss_a;
    logic stall_b, rd_b, wr_b, done_b, busy_b, urg_b, miss_b;
    logic [2:0] addr_a, addr_b;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    refresh_scheduler #(.ADDR_W(3), .REF_INTERVAL(INT_A), .RD_CYCLES(RD),
                        .WR_CYCLES(WR), .MAX_PEND(MAXP)) dut_a (
        .clk(clk), .rst(rst), .ref_en(ref_en), .wr_req(wr_req), .rd_req(rd_req),
        .host_stall(stall_a), .mem_ref_rd(rd_a), .mem_ref_wr(wr_a),
        .ref_mem_addr(addr_a), .ref_done(done_a), .ref_busy(busy_a),
        .ref_urgent(urg_a), .ref_miss(miss_a));

    refresh_scheduler #(.ADDR_W(3), .REF_INTERVAL(INT_B), .RD_CYCLES(RD),
                        .WR_CYCLES(WR), .MAX_PEND(MAXP)) dut_b (
        .clk(clk), .rst(rst), .ref_en(ref_en), .wr_req(wr_req), .rd_req(rd_req),
        .host_stall(stall_b), .mem_ref_rd(rd_b), .mem_ref_wr(wr_b),
        .ref_mem_addr(addr_b), .ref_done(done_b), .ref_busy(busy_b),
        .ref_urgent(urg_b), .ref_miss(miss_b));

    // pos: 0 = no refresh, 1..RD read, RD+1..RD+WR write-back, LAST = completion cycle
    typedef struct {
        int timer;
        int pend;
        int pos;
        int addr;
        bit miss;
    } model_t;

    model_t ma, mb;

    function automatic bit m_start(model_t m, bit en, bit w, bit r);
        return (m.pos == 0) && en && (m.pend > 0) && (!(w || r) || (m.pend == MAXP));
    endfunction

    function automatic model_t m_next(model_t m, bit rs, bit en, bit w, bit r, int interval);
        model_t n;
        bit tk, dn, st;
        n = m;
        if (rs) begin
            n.timer = 0; n.pend = 0; n.pos = 0; n.addr = 0; n.miss = 0;
            return n;
        end
        tk = en && (m.timer == interval - 1);
        dn = (m.pos == LAST);
        st = m_start(m, en, w, r);
        if (en) n.timer = (m.timer + 1) % interval;
        if (tk && !dn) begin
            if (m.pend == MAXP) n.miss = 1;
            else n.pend = m.pend + 1;
        end else if (dn && !tk) begin
            n.pend = m.pend - 1;
        end
        if (st) n.pos = 1;
        else if (dn) begin
            n.pos  = 0;
            n.addr = (m.addr + 1) % 8;
        end else if (m.pos > 0) n.pos = m.pos + 1;
        return n;
    endfunction

    task automatic cmp(string name, int act, int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_inst(string tag, model_t m, logic stall, logic rd, logic wr,
                              logic [2:0] addr, logic done, logic busy, logic urg, logic miss);
        bit e_rd, e_wr, e_done, e_busy, e_stall;
        e_busy  = (m.pos > 0);
        e_rd    = (m.pos >= 1) && (m.pos <= RD);
        e_wr    = (m.pos > RD) && (m.pos <= RD + WR);
        e_done  = (m.pos == LAST);
        e_stall = e_busy || m_start(m, ref_en, wr_req, rd_req);
        cmp({tag, "_host_stall"}, int'(stall), int'(e_stall));
        cmp({tag, "_mem_ref_rd"}, int'(rd), int'(e_rd));
        cmp({tag, "_mem_ref_wr"}, int'(wr), int'(e_wr));
        cmp({tag, "_ref_done"},   int'(done), int'(e_done));
        cmp({tag, "_ref_busy"},   int'(busy), int'(e_busy));
        cmp({tag, "_ref_urgent"}, int'(urg), int'(m.pend == MAXP));
        cmp({tag, "_ref_miss"},   int'(miss), int'(m.miss));
        cmp({tag, "_ref_mem_addr"}, int'(addr), m.addr);
    endtask

    // Advance one clock: update models with the inputs seen at the edge, then compare.
    task automatic step();
        ma = m_next(ma, rst, ref_en, wr_req, rd_req, INT_A);
        mb = m_next(mb, rst, ref_en, wr_req, rd_req, INT_B);
        @(posedge clk);
        #1;
        cyc++;
        check_inst("a", ma, stall_a, rd_a, wr_a, addr_a, done_a, busy_a, urg_a, miss_a);
        check_inst("b", mb, stall_b, rd_b, wr_b, addr_b, done_b, busy_b, urg_b, miss_b);
    endtask

    task automatic do_reset();
        rst = 1'b1; ref_en = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(int target);
        while (cyc < target) step();
    endtask

    typedef struct {
        int   cyc;
        bit   rd_req;
        bit   wr_req;
        bit   stall;
        bit   rd;
        bit   wr;
        bit   done;
        logic [2:0] addr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int ndone;
        bit prev_done;

        tbl[0] = '{14, 0, 0, 0, 0, 0, 0, 3'd0};
        tbl[1] = '{15, 0, 0, 0, 0, 0, 0, 3'd0};
        tbl[2] = '{16, 0, 0, 1, 0, 0, 0, 3'd0};
        tbl[3] = '{17, 0, 0, 1, 1, 0, 0, 3'd0};
        tbl[4] = '{18, 0, 0, 1, 1, 0, 0, 3'd0};
        tbl[5] = '{19, 0, 0, 1, 0, 1, 0, 3'd0};
        tbl[6] = '{20, 0, 0, 1, 0, 1, 0, 3'd0};
        tbl[7] = '{21, 0, 0, 1, 0, 0, 1, 3'd0};
        tbl[8] = '{22, 0, 0, 0, 0, 0, 0, 3'd1};
        tbl[9] = '{23, 0, 0, 0, 0, 0, 0, 3'd1};

        ma = '{0, 0, 0, 0, 0};
        mb = '{0, 0, 0, 0, 0};

        // Basic latency with an idle host
        do_reset();
        cmp("reset_stall", int'(stall_a), 0);
        cmp("reset_busy",  int'(busy_a), 0);
        cmp("reset_addr",  int'(addr_a), 0);
        for (int i = 0; i < 10; i++) begin
            rd_req = tbl[i].rd_req;
            wr_req = tbl[i].wr_req;
            run_to(tbl[i].cyc);
            cmp("t1_stall", int'(stall_a), int'(tbl[i].stall));
            cmp("t1_rd",    int'(rd_a),    int'(tbl[i].rd));
            cmp("t1_wr",    int'(wr_a),    int'(tbl[i].wr));
            cmp("t1_done",  int'(done_a),  int'(tbl[i].done));
            cmp("t1_addr",  int'(addr_a),  int'(tbl[i].addr));
        end

        // Host read traffic defers refresh until urgency forces it
        do_reset();
        rd_req = 1'b1;
        run_to(31);
        cmp("t2_deferred_stall", int'(stall_a), 0);
        cmp("t2_urgent_before", int'(urg_a), 0);
        run_to(32);
        cmp("t2_urgent", int'(urg_a), 1);
        cmp("t2_start_stall", int'(stall_a), 1);
        run_to(33);
        cmp("t2_rd", int'(rd_a), 1);
        run_to(37);
        cmp("t2_done", int'(done_a), 1);
        run_to(40);
        cmp("t2_after_busy", int'(busy_a), 0);
        cmp("t2_after_urgent", int'(urg_a), 0);
        run_to(48);
        cmp("t2_urgent_again", int'(urg_a), 1);
        rd_req = 1'b0;

        // Nine back-to-back refreshes: row pointer walks and wraps
        do_reset();
        ndone = 0;
        prev_done = 1'b0;
        while (cyc < 160) begin
            step();
            if (done_a) begin
                cmp("t3_done_width", int'(prev_done), 0);
                cmp("t3_done_addr", int'(addr_a), ndone % 8);
                ndone++;
            end
            prev_done = done_a;
        end
        cmp("t3_done_count", ndone, 9);
        cmp("t3_final_addr", int'(addr_a), 1);

        // Sustained writes on the short-interval instance lose a tick
        do_reset();
        wr_req = 1'b1;
        run_to(20);
        cmp("t4_miss_set", int'(miss_b), 1);
        wr_req = 1'b0;
        run_to(40);
        cmp("t4_miss_sticky", int'(miss_b), 1);
        rst = 1'b1;
        step();
        cmp("t4_miss_cleared", int'(miss_b), 0);
        rst = 1'b0;

        // ref_en drops mid write-back: refresh completes, timer freezes
        do_reset();
        run_to(19);
        cmp("t5_in_write", int'(wr_a), 1);
        ref_en = 1'b0;
        run_to(21);
        cmp("t5_done", int'(done_a), 1);
        run_to(50);
        cmp("t5_no_start", int'(busy_a), 0);
        ref_en = 1'b1;
        run_to(62);
        cmp("t5_pre_tick_stall", int'(stall_a), 0);
        run_to(63);
        cmp("t5_resume_stall", int'(stall_a), 1);
        run_to(64);
        cmp("t5_resume_rd", int'(rd_a), 1);

        // Reset during READ aborts with no completion pulse
        do_reset();
        run_to(17);
        cmp("t6_in_read", int'(rd_a), 1);
        rst = 1'b1;
        step();
        cmp("t6_rd", int'(rd_a), 0);
        cmp("t6_busy", int'(busy_a), 0);
        cmp("t6_done", int'(done_a), 0);
        cmp("t6_addr", int'(addr_a), 0);
        cmp("t6_stall", int'(stall_a), 0);
        rst = 1'b0;
        cyc = 0;
        ndone = 0;
        while (cyc < 10) begin
            step();
            if (done_a) ndone++;
        end
        cmp("t6_no_done", ndone, 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 299) == 0);
            ref_en = ($urandom_range(0, 9) != 0);
            wr_req = ($urandom_range(0, 3) == 0);
            rd_req = ($urandom_range(0, 3) == 0);
            if (i >= 1500 && i < 1800) begin
                wr_req = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
